// File: rtl/audio_pkg.sv
// Shared types and constants for the I2S codec endpoint.
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LEFT,
    RIGHT
  } state_t;

  localparam int DELAY_SLOT = 1;

endpackage

// File: rtl/pin_sync.sv
// Reset-clearable multi-flop synchronizer for one asynchronous pin.
module pin_sync #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] ff;

  always_ff @(posedge clk) begin
    if (rst) ff <= '0;
    else     ff <= (ff << 1) | DEPTH'(d);
  end

  assign q = ff[DEPTH-1];

endmodule

// File: rtl/i2s_codec_endpoint.sv
// I2S slave endpoint: deserializes DACDAT frames, serializes ADCDAT frames.
// Optional short-half detection when AUD_FRAME_CHECK_EN is defined.
module i2s_codec_endpoint
  import audio_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              AUD_BCLK,
  input  logic              AUD_LRCK,
  input  logic              AUD_DACDAT,
  output logic              AUD_ADCDAT,
  output logic [DATA_W-1:0] rx_left,
  output logic [DATA_W-1:0] rx_right,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_left,
  input  logic [DATA_W-1:0] tx_right,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_underrun,
  output logic              frame_err
);

  localparam int CW = $clog2(DATA_W + 2);
  localparam logic [CW-1:0] FIRST = CW'(DELAY_SLOT);
  localparam logic [CW-1:0] LAST  = CW'(DELAY_SLOT + DATA_W - 1);
  localparam logic [CW-1:0] FULL  = CW'(DELAY_SLOT + DATA_W);
  localparam logic [CW-1:0] NBIT  = CW'(DATA_W);

  logic bclk_s, lrck_s, dat_s;
  logic bclk_d, lrck_d;

  pin_sync #(.DEPTH(SYNC_STAGES)) u_bclk (
    .clk(iCLK), .rst(iRST), .d(AUD_BCLK), .q(bclk_s));
  pin_sync #(.DEPTH(SYNC_STAGES)) u_lrck (
    .clk(iCLK), .rst(iRST), .d(AUD_LRCK), .q(lrck_s));
  pin_sync #(.DEPTH(SYNC_STAGES)) u_dat (
    .clk(iCLK), .rst(iRST), .d(AUD_DACDAT), .q(dat_s));

  state_t state, state_n;

  logic bclk_rise, bclk_fall;
  logic lrck_rise, lrck_fall, lrck_edge;
  logic active, load, xfer, capture, last_rise;
  logic left_bad;

  logic [CW-1:0]     rcnt, fcnt;
  logic [DATA_W-1:0] sh_l, sh_r;
  logic [DATA_W-1:0] tsh_l, tsh_r;
  logic [DATA_W-1:0] hold_l, hold_r;
  logic              hold_full;

  assign bclk_rise = bclk_s & ~bclk_d;
  assign bclk_fall = ~bclk_s & bclk_d;
  assign lrck_rise = lrck_s & ~lrck_d;
  assign lrck_fall = ~lrck_s & lrck_d;
  assign lrck_edge = lrck_rise | lrck_fall;
  assign active    = (state != IDLE);
  assign load      = active & lrck_fall;
  assign xfer      = tx_valid & ~hold_full;
  assign tx_ready  = ~hold_full;

  assign capture   = active & bclk_rise & ~lrck_edge
                   & (rcnt >= FIRST) & (rcnt <= LAST);
  assign last_rise = capture & (state == RIGHT) & (rcnt == LAST);

  always_ff @(posedge iCLK) begin
    if (iRST) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (lrck_fall) state_n = LEFT;
      LEFT:    if (lrck_rise) state_n = RIGHT;
      RIGHT:   if (lrck_fall) state_n = LEFT;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      bclk_d      <= 1'b0;
      lrck_d      <= 1'b0;
      rcnt        <= '0;
      fcnt        <= '0;
      sh_l        <= '0;
      sh_r        <= '0;
      tsh_l       <= '0;
      tsh_r       <= '0;
      hold_l      <= '0;
      hold_r      <= '0;
      hold_full   <= 1'b0;
      rx_left     <= '0;
      rx_right    <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      AUD_ADCDAT  <= 1'b0;
    end else begin
      bclk_d      <= bclk_s;
      lrck_d      <= lrck_s;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;

      if (lrck_edge) rcnt <= '0;
      else if (active && bclk_rise && rcnt != FULL) rcnt <= rcnt + 1'b1;

      if (lrck_edge) fcnt <= '0;
      else if (active && bclk_fall && fcnt != NBIT) fcnt <= fcnt + 1'b1;

      if (capture) begin
        if (state == LEFT) sh_l <= {sh_l[DATA_W-2:0], dat_s};
        else               sh_r <= {sh_r[DATA_W-2:0], dat_s};
      end

      if (last_rise && !left_bad) begin
        rx_left  <= sh_l;
        rx_right <= {sh_r[DATA_W-2:0], dat_s};
        rx_valid <= 1'b1;
      end

      // A same-cycle offer lands in the buffer after the frame load empties it
      if (xfer) begin
        hold_l    <= tx_left;
        hold_r    <= tx_right;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end

      if (load) begin
        if (hold_full) begin
          tsh_l <= hold_l;
          tsh_r <= hold_r;
        end else begin
          tsh_l       <= '0;
          tsh_r       <= '0;
          tx_underrun <= 1'b1;
        end
      end

      if (!active || lrck_edge) begin
        AUD_ADCDAT <= 1'b0;
      end else if (bclk_fall) begin
        if (fcnt < NBIT) begin
          if (state == LEFT) begin
            AUD_ADCDAT <= tsh_l[DATA_W-1];
            tsh_l      <= tsh_l << 1;
          end else begin
            AUD_ADCDAT <= tsh_r[DATA_W-1];
            tsh_r      <= tsh_r << 1;
          end
        end else begin
          AUD_ADCDAT <= 1'b0;
        end
      end
    end
  end

`ifdef AUD_FRAME_CHECK_EN
  logic short_end;
  assign short_end = active & lrck_edge & (rcnt < FULL);

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      frame_err <= 1'b0;
      left_bad  <= 1'b0;
    end else begin
      frame_err <= short_end;
      if (lrck_rise && state == LEFT) left_bad <= (rcnt < FULL);
      else if (lrck_fall)             left_bad <= 1'b0;
    end
  end
`else
  assign frame_err = 1'b0;
  assign left_bad  = 1'b0;
`endif

endmodule

// File: doc/i2s_codec_endpoint.md
I2S_CODEC_ENDPOINT -- requirements
Module: i2s_codec_endpoint

Interface
REQ-001 SHALL have parameter DATA_W, default 16, giving sample width per channel.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, giving the flop depth of each pin synchronizer.
REQ-003 SHALL have port iCLK, input, 1, the single system clock (50 MHz).
REQ-004 SHALL have port iRST, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port AUD_BCLK, input, 1, the asynchronous bit clock from the audio_clock master.
REQ-006 SHALL have port AUD_LRCK, input, 1, the asynchronous frame clock; low = left, high = right.
REQ-007 SHALL have port AUD_DACDAT, input, 1, the serial data driven by the converter.
REQ-008 SHALL have port AUD_ADCDAT, output, 1, the serial data returned to the converter.
REQ-009 SHALL have ports rx_left and rx_right, output, DATA_W each, the last deserialized frame.
REQ-010 SHALL have port rx_valid, output, 1, a one-cycle pulse marking a new frame on rx_left/rx_right.
REQ-011 SHALL have ports tx_left and tx_right (input, DATA_W each) and tx_valid (input, 1), the sample offer.
REQ-012 SHALL have port tx_ready, output, 1, high while the holding buffer is empty.
REQ-013 SHALL have ports tx_underrun and frame_err, output, 1 each, one-cycle event pulses.

Function
REQ-014 SHALL pass AUD_BCLK, AUD_LRCK and AUD_DACDAT through equal-depth SYNC_STAGES synchronizers and detect edges on the synchronized copies; supported BCLK is at most iCLK/8.
REQ-015 SHALL run an FSM IDLE -> LEFT on the first LRCK falling edge, LEFT -> RIGHT on each LRCK rising edge and RIGHT -> LEFT on each LRCK falling edge; IDLE ignores BCLK.
REQ-016 SHALL clear a per-half counter of BCLK rising edges at each LRCK edge.
REQ-017 SHALL ignore rise 1 of each half as the I2S delay slot, capture DACDAT MSB-first on rises 2..DATA_W+1, and ignore any later rises.
REQ-018 SHALL present rx_left/rx_right and pulse rx_valid exactly one cycle after rise DATA_W+1 of the RIGHT half; the outputs hold until the next pulse.
REQ-019 SHALL implement a one-entry holding buffer: tx_ready = ~hold_full, and a transfer occurs when tx_valid && tx_ready.
REQ-020 SHALL, on each LRCK falling edge outside IDLE, load both TX shift registers from the buffer and empty it; if the buffer is empty, it SHALL load zeros and pulse tx_underrun.
REQ-021 SHALL treat a transfer coinciding with a frame load into an empty buffer as an underrun for the current frame; the new sample fills the buffer for the next frame.
REQ-022 SHALL drive AUD_ADCDAT one iCLK cycle after each BCLK falling edge: bit DATA_W-f on fall f (f = 1..DATA_W after the LRCK edge) and 0 otherwise; LEFT uses the left register and RIGHT the right register.
REQ-023 SHALL hold AUD_ADCDAT at 0 in IDLE.

Reset
REQ-024 SHALL, while iRST is high, force the FSM to IDLE, clear the synchronizers, counters, shift registers and holding buffer, and drive every output (rx_*, rx_valid, AUD_ADCDAT, tx_underrun, frame_err) to 0 except tx_ready, which is 1.
REQ-025 SHALL discard any partial frame when reset is asserted mid-frame; no rx_valid pulse occurs until a full frame completes after the next LRCK falling edge.

Configuration
REQ-026 SHALL, with AUD_FRAME_CHECK_EN defined, pulse frame_err at any LRCK edge ending a half with fewer than DATA_W+1 BCLK rises; a short LEFT half SHALL also suppress that frame's rx_valid.
REQ-027 SHALL, without AUD_FRAME_CHECK_EN, tie frame_err to 0 and never suppress rx_valid.

Structure
REQ-028 SHALL place the FSM state enum and the I2S delay-slot constant (1) in shared package audio_pkg.
REQ-029 SHALL instantiate sub-module pin_sync (parameterised depth, one per pin) for the synchronizers.

Verification
REQ-030 SHALL cover loopback: BCLK = iCLK/16, 32 BCLK per half, DACDAT frame L=16'hA55A, R=16'h1234 -> one rx_valid with rx_left=16'hA55A, rx_right=16'h1234.
REQ-031 SHALL cover TX: tx_left=16'h8001 and tx_right=16'h7FFE transferred before the frame -> ADCDAT reproduces those bits MSB-first on fall 1..16 of each half, 0 elsewhere, and tx_ready returns to 1 at the load.
REQ-032 SHALL cover underrun: no transfer before an LRCK falling edge -> ADCDAT all zeros for that frame and one tx_underrun pulse.
REQ-033 SHALL cover a simultaneous transfer and frame load into an empty buffer -> current frame zeros plus tx_underrun, and the next frame carries the transferred sample.
REQ-034 SHALL cover a short half: LEFT half of 10 BCLK with AUD_FRAME_CHECK_EN -> frame_err pulse and no rx_valid; without the macro -> rx_valid is still emitted.
REQ-035 SHALL cover reset mid-frame: iRST pulsed at rise 8 of LEFT -> all outputs 0, tx_ready 1, and the first rx_valid only after one complete subsequent frame.
